// File: rtl/gon_collector.sv
// GON collector: round-robin merge of NUM_SOURCES tagged result streams into one sink register.
// Optional word counter enabled by defining GON_STATS_EN.
module gon_collector #(
    parameter int BITWIDTH    = 16,
    parameter int TAG_LENGTH  = 4,
    parameter int NUM_SOURCES = 10
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            program_en,
    input  logic [TAG_LENGTH-1:0]           scan_tag_in,
    output logic [TAG_LENGTH-1:0]           scan_tag_out,
    input  logic [NUM_SOURCES-1:0]          source_valid,
    input  logic [BITWIDTH*NUM_SOURCES-1:0] source_data,
    output logic [NUM_SOURCES-1:0]          source_ready,
    output logic                            sink_valid,
    output logic [BITWIDTH-1:0]             sink_data,
    output logic [TAG_LENGTH-1:0]           sink_tag,
`ifdef GON_STATS_EN
    output logic [15:0]                     word_count,
`endif
    input  logic                            sink_ready
);

    localparam int PW = $clog2(NUM_SOURCES);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [BITWIDTH-1:0]   sink_data_q, sink_data_d;
    logic [TAG_LENGTH-1:0] sink_tag_q, sink_tag_d;
    logic [TAG_LENGTH-1:0] tag_q [NUM_SOURCES];
    logic [TAG_LENGTH-1:0] tag_d [NUM_SOURCES];
    logic [BITWIDTH-1:0]   src_word [NUM_SOURCES];

    logic                  reg_free;
    logic                  grant_en;
    logic                  grant_found;
    logic                  grant_ok;
    logic [PW-1:0]         grant_idx;

    // (base + step) mod NUM_SOURCES, for base < NUM_SOURCES and step <= NUM_SOURCES
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_SOURCES) begin
            sum = sum - NUM_SOURCES;
        end
        return PW'(sum);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
            assign src_word[gi]     = source_data[BITWIDTH*gi +: BITWIDTH];
            assign source_ready[gi] = grant_ok && (grant_idx == PW'(gi));
            if (gi == 0) begin : g_head
                assign tag_d[gi] = program_en ? scan_tag_in : tag_q[gi];
            end else begin : g_body
                assign tag_d[gi] = program_en ? tag_q[gi-1] : tag_q[gi];
            end
        end
    endgenerate

    // A drain in this cycle frees the register for a same-cycle refill.
    assign reg_free = (state_q == EMPTY) || sink_ready;
    assign grant_en = reg_free && !program_en && rstb;
    assign grant_ok = grant_en && grant_found;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (!grant_found && source_valid[wrap_inc(ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_inc(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sink_data_d = sink_data_q;
        sink_tag_d  = sink_tag_q;
        case (state_q)
            EMPTY: if (grant_ok) state_d = FULL;
            FULL:  if (sink_ready && !grant_ok) state_d = EMPTY;
        endcase
        if (grant_ok) begin
            sink_data_d = src_word[grant_idx];
            sink_tag_d  = tag_q[grant_idx];
            ptr_d       = wrap_inc(grant_idx, 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q     <= EMPTY;
            ptr_q       <= '0;
            sink_data_q <= '0;
            sink_tag_q  <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sink_data_q <= sink_data_d;
            sink_tag_q  <= sink_tag_d;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign sink_valid   = (state_q == FULL);
    assign sink_data    = sink_data_q;
    assign sink_tag     = sink_tag_q;
    assign scan_tag_out = tag_q[NUM_SOURCES-1];

`ifdef GON_STATS_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if ((state_q == FULL) && sink_ready && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign word_count = count_q;
`endif

endmodule

// File: tb/tb_gon_collector.sv
// Scoreboard bench for gon_collector: a queue-based reference of the arbiter and tag chain
// predicts grants and sink words; a separate monitor checks every word the sink presents.
module tb_gon_collector;
    localparam int BW = 16;
    localparam int TL = 4;
    localparam int N  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstb, program_en, sink_ready;
    logic [TL-1:0] scan_tag_in, scan_tag_out;
    logic [N-1:0]  source_valid, source_ready;
    logic [BW*N-1:0] source_data;
    logic          sink_valid;
    logic [BW-1:0] sink_data;
    logic [TL-1:0] sink_tag;
`ifdef GON_STATS_EN
    logic [15:0]   word_count;
`endif

    gon_collector #(.BITWIDTH(BW), .TAG_LENGTH(TL), .NUM_SOURCES(N)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .program_en   (program_en),
        .scan_tag_in  (scan_tag_in),
        .scan_tag_out (scan_tag_out),
        .source_valid (source_valid),
        .source_data  (source_data),
        .source_ready (source_ready),
        .sink_valid   (sink_valid),
        .sink_data    (sink_data),
        .sink_tag     (sink_tag),
`ifdef GON_STATS_EN
        .word_count   (word_count),
`endif
        .sink_ready   (sink_ready)
    );

    typedef struct packed {
        logic [BW-1:0] d;
        logic [TL-1:0] t;
    } word_t;

    int            errors = 0;
    int            checks = 0;
    logic [BW-1:0] src_data [N];
    logic [TL-1:0] m_tag [N];
    int            m_ptr;
    bit            m_full;
    int            m_count;
    word_t         exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare combinational/registered outputs to the model, advance the model.
    task automatic step(input logic [N-1:0] v, input bit sr, input bit prog, input bit rb,
                        input logic [TL-1:0] sti, output int g);
        logic [N-1:0] exp_rdy;
        bit           free;
        @(negedge clk);
        source_valid = v;
        sink_ready   = sr;
        program_en   = prog;
        rstb         = rb;
        scan_tag_in  = sti;
        for (int i = 0; i < N; i++) source_data[BW*i +: BW] = src_data[i];
        #2;
        g    = -1;
        free = !m_full || sr;
        if (rb && free && !prog) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("source_ready", 32'(source_ready), 32'(exp_rdy));
        check("sink_valid", 32'(sink_valid), 32'(m_full));
        check("scan_tag_out", 32'(scan_tag_out), 32'(m_tag[N-1]));
`ifdef GON_STATS_EN
        check("word_count", 32'(word_count), 32'(m_count));
`endif
        $display("cycle v=%03h sr=%0d prog=%0d rstb=%0d grant=%0d", v, sr, prog, rb, g);
        if (!rb) begin
            m_full  = 1'b0;
            m_ptr   = 0;
            m_count = 0;
            for (int i = 0; i < N; i++) m_tag[i] = '0;
            exp_q.delete();
        end else begin
            if (m_full && sr && m_count < 65535) m_count++;
            if (g >= 0) begin
                exp_q.push_back('{d: src_data[g], t: m_tag[g]});
                m_ptr  = (g + 1) % N;
                m_full = 1'b1;
            end else if (sr) begin
                m_full = 1'b0;
            end
            if (prog) begin
                for (int i = N - 1; i > 0; i--) m_tag[i] = m_tag[i-1];
                m_tag[0] = sti;
            end
        end
    endtask

    // Monitor: whatever the sink shows must be the oldest outstanding word; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (sink_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sink_unexpected: got data %0h tag %0h, required no word", sink_data, sink_tag);
                end else begin
                    check("sink_data", 32'(sink_data), 32'(exp_q[0].d));
                    check("sink_tag", 32'(sink_tag), 32'(exp_q[0].t));
                    if (sink_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    int           g;
    logic [N-1:0] v_hold;
    int           rr_order [3] = '{1, 4, 7};

    initial begin
        rstb = 1'b0; program_en = 1'b0; sink_ready = 1'b0;
        source_valid = '0; source_data = '0; scan_tag_in = '0;
        m_ptr = 0; m_full = 1'b0; m_count = 0;
        for (int i = 0; i < N; i++) begin
            src_data[i] = BW'($urandom);
            m_tag[i]    = '0;
        end
        repeat (2) @(posedge clk);

        // Reset holds off grants even with every source valid; source 0 wins first after release.
        step('1, 1'b1, 1'b0, 1'b0, '0, g);
        step('1, 1'b1, 1'b0, 1'b1, '0, g);
        check("reset_sink_tag", 32'(sink_tag), 32'd0);
        check("reset_first_grant", 32'(source_ready), 32'd1);

        // Scan tags 9..0, then source 3 carries tag 3.
        for (int i = 0; i < N; i++) step('0, 1'b1, 1'b1, 1'b1, TL'(9 - i), g);
        src_data[3] = 16'hABCD;
        step(10'(1 << 3), 1'b1, 1'b0, 1'b1, '0, g);
        check("scan_grant3", 32'(source_ready), 32'(1 << 3));
        step('0, 1'b1, 1'b0, 1'b1, '0, g);
        check("scan_data", 32'(sink_data), 32'hABCD);
        check("scan_tag", 32'(sink_tag), 32'd3);

        // Round-robin among sources 1, 4, 7.
        step('0, 1'b1, 1'b0, 1'b0, '0, g);
        for (int i = 0; i < 6; i++) begin
            step(10'b0010010010, 1'b1, 1'b0, 1'b1, '0, g);
            check("rr_grant", 32'(source_ready), 32'(1 << rr_order[i % 3]));
        end

        // Backpressure: word from 2 held for 5 cycles, then 5 granted on the release cycle.
        step('0, 1'b1, 1'b0, 1'b0, '0, g);
        src_data[2] = BW'($urandom);
        src_data[5] = BW'($urandom);
        step(10'(1 << 2), 1'b0, 1'b0, 1'b1, '0, g);
        check("bp_grant2", 32'(source_ready), 32'(1 << 2));
        for (int i = 0; i < 5; i++) begin
            step(10'(1 << 5), 1'b0, 1'b0, 1'b1, '0, g);
            check("bp_stall_ready", 32'(source_ready), 32'd0);
            check("bp_hold_data", 32'(sink_data), 32'(src_data[2]));
        end
        step(10'(1 << 5), 1'b1, 1'b0, 1'b1, '0, g);
        check("bp_grant5", 32'(source_ready), 32'(1 << 5));

        // Program while FULL: held word drains, no new grant until program drops.
        step(10'(1 << 8), 1'b0, 1'b1, 1'b1, 4'h6, g);
        step(10'(1 << 8), 1'b1, 1'b1, 1'b1, 4'h2, g);
        check("prog_block", 32'(source_ready), 32'd0);
        step(10'(1 << 8), 1'b1, 1'b1, 1'b1, 4'h9, g);
        check("prog_empty", 32'(sink_valid), 32'd0);
        step(10'(1 << 8), 1'b1, 1'b0, 1'b1, '0, g);
        check("prog_release", 32'(source_ready), 32'(1 << 8));

        // Reset while FULL drops the held word.
        step('0, 1'b0, 1'b0, 1'b1, '0, g);
        step('0, 1'b0, 1'b0, 1'b0, '0, g);
        step('0, 1'b0, 1'b0, 1'b1, '0, g);
        check("rst_full", 32'(sink_valid), 32'd0);

        // Random traffic; sources hold their word until granted.
        v_hold = '0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v_hold[i] && ($urandom % 3 == 0)) begin
                    v_hold[i]   = 1'b1;
                    src_data[i] = BW'($urandom);
                end
            end
            step(v_hold, ($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 64) != 0,
                 TL'($urandom), g);
            if (g >= 0) v_hold[g] = 1'b0;
        end

`ifdef GON_STATS_EN
        step('0, 1'b1, 1'b0, 1'b0, '0, g);
        for (int c = 0; c < 70002; c++) step('1, 1'b1, 1'b0, 1'b1, '0, g);
        check("stats_saturate", 32'(word_count), 32'hFFFF);
`endif

        for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0, 1'b1, '0, g);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
